timer_entry_control: RTL and testbench

Front-end stage of the timer and control input path. Captures BCD digits from the keypad encoder into a 4-digit mm:ss preset. Validates the preset, then pulses a load into the downstream cascaded non-recycling (stop-at-zero) down-counters. Runs the start/pause/clear state machine that gates those counters' count enable.

---
 rtl/timer_entry_control.sv | 141 ++++++++++++++
 tb/tb_timer_entry_control.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_entry_control.sv
// Keypad-to-timer front end: captures an mm:ss BCD preset, validates it, pulses a load
// into the downstream stop-at-zero down-counters and gates their count enable through a
// start/pause/clear state machine.
module timer_entry_control #(
  parameter int unsigned MAX_DIGITS  = 4,  // fixed mm:ss layout, only 4 supported
  parameter int unsigned MAX_SS_TENS = 5
) (
  input  logic        clock,
  input  logic        clear,          // asynchronous, active low
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        start_key,
  input  logic        stop_key,
  input  logic        door_closed,
  input  logic        counting_done,
  output logic [15:0] preset,
  output logic        load,
  output logic        count_enable,
  output logic        done_pulse,
  output logic        entry_error,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StEntry = 2'd1,
    StRun   = 2'd2,
    StPause = 2'd3
  } state_e;

  localparam logic [2:0] DigitsMax = 3'(MAX_DIGITS);
  localparam logic [3:0] SsTensMax = 4'(MAX_SS_TENS);

  state_e      state_q, state_d;
  logic [15:0] preset_q, preset_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        load_q, load_d;
  logic        cen_q, cen_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        key_q, start_q, stop_q;

  logic key_ev, start_ev, stop_ev;
  logic preset_ok;

  assign key_ev   = key_valid & ~key_q;
  assign start_ev = start_key & ~start_q;
  assign stop_ev  = stop_key & ~stop_q;

  // Nonzero preset with a legal tens-of-seconds digit, and the door interlock closed.
  assign preset_ok = (preset_q != 16'h0000) && (preset_q[7:4] <= SsTensMax) && door_closed;

  // Next-state, preset capture and output pulses; priority done > stop > door > start > digit.
  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    cnt_d    = cnt_q;
    load_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle, StEntry: begin
        if (load_q) begin
          // Load was pulsed last cycle; counters hold the preset, start counting now.
          state_d = StRun;
        end else if (stop_ev && (state_q == StEntry)) begin
          state_d  = StIdle;
          preset_d = 16'h0000;
          cnt_d    = 3'd0;
        end else if (start_ev && (state_q == StEntry)) begin
          if (preset_ok) load_d = 1'b1;
          else           err_d  = 1'b1;
        end else if (key_ev) begin
          if (key_code > 4'd9 || cnt_q >= DigitsMax) begin
            err_d = 1'b1;
          end else begin
            preset_d = {preset_q[11:0], key_code};
            cnt_d    = cnt_q + 3'd1;
            state_d  = StEntry;
          end
        end
      end
      StRun: begin
        if (counting_done) begin
          state_d  = StIdle;
          done_d   = 1'b1;
          preset_d = 16'h0000;
          cnt_d    = 3'd0;
        end else if (stop_ev || !door_closed) begin
          state_d = StPause;
        end
      end
      StPause: begin
        if (stop_ev) begin
          state_d  = StIdle;
          preset_d = 16'h0000;
          cnt_d    = 3'd0;
        end else if (start_ev && door_closed) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
    cen_d = (state_d == StRun);
  end

  // State, preset and registered outputs; edge-detect copies of the button/key levels.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q  <= StIdle;
      preset_q <= 16'h0000;
      cnt_q    <= 3'd0;
      load_q   <= 1'b0;
      cen_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      key_q    <= 1'b0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      preset_q <= preset_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
      cen_q    <= cen_d;
      done_q   <= done_d;
      err_q    <= err_d;
      key_q    <= key_valid;
      start_q  <= start_key;
      stop_q   <= stop_key;
    end
  end

  assign preset       = preset_q;
  assign load         = load_q;
  assign count_enable = cen_q;
  assign done_pulse   = done_q;
  assign entry_error  = err_q;
  assign state        = state_q;

endmodule

// File: tb/tb_timer_entry_control.sv
// Directed bench for timer_entry_control with hand-computed expectations.
module tb_timer_entry_control;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        start_key;
  logic        stop_key;
  logic        door_closed;
  logic        counting_done;
  logic [15:0] preset;
  logic        load;
  logic        count_enable;
  logic        done_pulse;
  logic        entry_error;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  timer_entry_control #(
    .MAX_DIGITS (4),
    .MAX_SS_TENS(5)
  ) dut (
    .clock        (clk),
    .clear        (rst_n),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .start_key    (start_key),
    .stop_key     (stop_key),
    .door_closed  (door_closed),
    .counting_done(counting_done),
    .preset       (preset),
    .load         (load),
    .count_enable (count_enable),
    .done_pulse   (done_pulse),
    .entry_error  (entry_error),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock, then sample/drive 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic key_down(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    step();
  endtask

  task automatic key_up();
    key_valid = 1'b0;
    step();
  endtask

  task automatic key(input logic [3:0] code);
    key_down(code);
    key_up();
  endtask

  task automatic press_stop();
    stop_key = 1'b1;
    step();
    stop_key = 1'b0;
    step();
  endtask

  // Enter 1,3,0 and start with the door closed; ends in RUNNING.
  task automatic enter_and_run();
    key(4'd1);
    key(4'd3);
    key(4'd0);
    check("run_preset", 32'(preset), 32'h0130);
    start_key = 1'b1;
    step();
    check("run_load", 32'(load), 32'd1);
    check("run_load_cen", 32'(count_enable), 32'd0);
    check("run_load_state", 32'(state), 32'd1);
    start_key = 1'b0;
    step();
    check("run_load_gone", 32'(load), 32'd0);
    check("run_cen", 32'(count_enable), 32'd1);
    check("run_state", 32'(state), 32'd2);
  endtask

  initial begin
    rst_n = 1'b0;
    key_valid = 1'b0;
    key_code = 4'd0;
    start_key = 1'b0;
    stop_key = 1'b0;
    door_closed = 1'b1;
    counting_done = 1'b0;
    #22;
    check("rst_state", 32'(state), 32'd0);
    check("rst_outs", {11'd0, load, count_enable, done_pulse, entry_error, preset}, 32'd0);
    rst_n = 1'b1;
    step();

    // Entry and accepted start.
    enter_and_run();
    step();
    check("run_load_once", 32'(load), 32'd0);

    // Asynchronous reset mid-RUNNING, checked before the next edge.
    #3 rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_preset", 32'(preset), 32'd0);
    check("arst_cen", 32'(count_enable), 32'd0);
    #1 rst_n = 1'b1;
    step();

    // ss_tens = 9 (keys 9,0 give 16'h0090) is rejected.
    key(4'd9);
    key(4'd0);
    check("bad_preset", 32'(preset), 32'h0090);
    start_key = 1'b1;
    step();
    check("bad_err", 32'(entry_error), 32'd1);
    check("bad_noload", 32'(load), 32'd0);
    check("bad_state", 32'(state), 32'd1);
    start_key = 1'b0;
    step();
    check("bad_err_once", 32'(entry_error), 32'd0);
    check("bad_still_entry", 32'(state), 32'd1);
    press_stop();
    check("bad_stop_state", 32'(state), 32'd0);
    check("bad_stop_preset", 32'(preset), 32'd0);

    // All-zero preset is rejected too.
    key(4'd0);
    check("zero_state", 32'(state), 32'd1);
    start_key = 1'b1;
    step();
    check("zero_err", 32'(entry_error), 32'd1);
    check("zero_noload", 32'(load), 32'd0);
    start_key = 1'b0;
    step();
    press_stop();
    check("zero_idle", 32'(state), 32'd0);

    // Digit saturation and illegal key code.
    key(4'd1);
    key(4'd2);
    key(4'd3);
    key(4'd4);
    check("four_preset", 32'(preset), 32'h1234);
    key_down(4'd5);
    check("fifth_err", 32'(entry_error), 32'd1);
    check("fifth_preset", 32'(preset), 32'h1234);
    key_up();
    check("fifth_err_once", 32'(entry_error), 32'd0);
    key_down(4'hB);
    check("hexb_err", 32'(entry_error), 32'd1);
    check("hexb_preset", 32'(preset), 32'h1234);
    key_up();
    press_stop();
    check("sat_idle_preset", 32'(preset), 32'd0);

    // Door open pauses, start resumes without a load.
    enter_and_run();
    door_closed = 1'b0;
    step();
    check("door_state", 32'(state), 32'd3);
    check("door_cen", 32'(count_enable), 32'd0);
    door_closed = 1'b1;
    start_key = 1'b1;
    step();
    check("resume_state", 32'(state), 32'd2);
    check("resume_cen", 32'(count_enable), 32'd1);
    check("resume_noload", 32'(load), 32'd0);
    check("resume_preset", 32'(preset), 32'h0130);
    start_key = 1'b0;
    step();

    // Completion beats a simultaneous stop.
    counting_done = 1'b1;
    stop_key = 1'b1;
    step();
    check("done_pulse", 32'(done_pulse), 32'd1);
    check("done_state", 32'(state), 32'd0);
    check("done_preset", 32'(preset), 32'd0);
    check("done_cen", 32'(count_enable), 32'd0);
    counting_done = 1'b0;
    stop_key = 1'b0;
    step();
    check("done_once", 32'(done_pulse), 32'd0);

    // A held key yields a single digit.
    key_valid = 1'b1;
    key_code = 4'd7;
    for (int i = 0; i < 10; i++) step();
    check("held_preset", 32'(preset), 32'h0007);
    check("held_state", 32'(state), 32'd1);
    key_up();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
